// File: rtl/ysyx_25060170_ifu_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, decode valid/ready
// and commit/redirect feedback. The fetch unit is the master; its environment is the slave.
interface ysyx_25060170_ifu_fetch_if;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        commit_valid;
  logic        commit_jump;
  logic [31:0] commit_target;

  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst_o, pc_o,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
           commit_valid, commit_jump, commit_target
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst_o, pc_o,
    output mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
           commit_valid, commit_jump, commit_target
  );
endinterface

// File: rtl/ysyx_25060170_ifu_fetch.sv
// Multi-cycle instruction fetch for a non-pipelined core: REQ -> RESP -> DELIVER -> COMMIT.
// Optional performance counters are enabled by defining YSYX_25060170_IFU_PERF_EN.
module ysyx_25060170_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                             clk,
  input  logic                             rst,
`ifdef YSYX_25060170_IFU_PERF_EN
  output logic [31:0]                      perf_fetch_cnt,
  output logic [31:0]                      perf_stall_cnt,
`endif
  ysyx_25060170_ifu_fetch_if.master        bus
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_RESP    = 2'd1,
    S_DELIVER = 2'd2,
    S_COMMIT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  // Set while rst is high so the request stays low without a combinational path from rst.
  logic        hold_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      hold_q  <= 1'b0;
    end
  end

  // Next-state logic.
  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      S_REQ: begin
        if (bus.mem_req_ready && !hold_q) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.mem_resp_valid) begin
          inst_d  = bus.mem_resp_data;
          state_d = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (bus.inst_ready) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (bus.commit_valid) begin
          pc_d    = bus.commit_jump ? (bus.commit_target & ~32'h0000_0003) : pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Output decode: handshake valids depend on registered state only.
  always_comb begin
    bus.mem_req_valid = 1'b0;
    bus.inst_valid    = 1'b0;
    case (state_q)
      S_REQ:     bus.mem_req_valid = !hold_q;
      S_DELIVER: bus.inst_valid    = 1'b1;
      default:   ;
    endcase
  end

  assign bus.mem_req_addr = pc_q;
  assign bus.pc_o         = pc_q;
  assign bus.inst_o       = inst_q;

`ifdef YSYX_25060170_IFU_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (state_q == S_DELIVER && bus.inst_ready) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if ((state_q == S_REQ  && !bus.mem_req_ready) ||
          (state_q == S_RESP && !bus.mem_resp_valid)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_25060170_ifu_fetch.sv
// Directed bench for ysyx_25060170_ifu_fetch; counter checks are added when
// YSYX_25060170_IFU_PERF_EN is defined.
module tb_ysyx_25060170_ifu_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  ysyx_25060170_ifu_fetch_if bus ();

`ifdef YSYX_25060170_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  ysyx_25060170_ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef YSYX_25060170_IFU_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .bus            (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.inst_ready     = 1'b0;
    bus.commit_valid   = 1'b0;
    bus.commit_jump    = 1'b0;
    bus.commit_target  = '0;
  endtask

  // From REQ at exp_pc: request accepted, response one cycle later, ends in DELIVER.
  task automatic fetch_word(input logic [31:0] w, input logic [31:0] exp_pc);
    checks++;
    if (bus.mem_req_valid !== 1'b1) begin
      failures++; $display("FAIL fetch_req_valid: got %b expected 1", bus.mem_req_valid);
    end
    checks++;
    if (bus.mem_req_addr !== exp_pc) begin
      failures++; $display("FAIL fetch_req_addr: got %h expected %h", bus.mem_req_addr, exp_pc);
    end
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = w;
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    checks++;
    if (bus.inst_valid !== 1'b1) begin
      failures++; $display("FAIL fetch_inst_valid: got %b expected 1", bus.inst_valid);
    end
    checks++;
    if (bus.inst_o !== w) begin
      failures++; $display("FAIL fetch_inst_o: got %h expected %h", bus.inst_o, w);
    end
    checks++;
    if (bus.pc_o !== exp_pc) begin
      failures++; $display("FAIL fetch_pc_o: got %h expected %h", bus.pc_o, exp_pc);
    end
  endtask

  // From DELIVER: decode handshake, then one commit pulse the next cycle; ends in REQ.
  task automatic commit(input logic jump, input logic [31:0] target);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready    = 1'b0;
    bus.commit_valid  = 1'b1;
    bus.commit_jump   = jump;
    bus.commit_target = target;
    tick();
    bus.commit_valid  = 1'b0;
    bus.commit_jump   = 1'b0;
    bus.commit_target = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.commit_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.mem_req_valid !== 1'b0) begin
      failures++; $display("FAIL reset_req_valid: got %b expected 0", bus.mem_req_valid);
    end
    checks++;
    if (bus.inst_valid !== 1'b0) begin
      failures++; $display("FAIL reset_inst_valid: got %b expected 0", bus.inst_valid);
    end
    checks++;
    if (bus.pc_o !== 32'h8000_0000) begin
      failures++; $display("FAIL reset_pc: got %h expected 80000000", bus.pc_o);
    end
    checks++;
    if (bus.inst_o !== 32'h0) begin
      failures++; $display("FAIL reset_inst_o: got %h expected 00000000", bus.inst_o);
    end
`ifdef YSYX_25060170_IFU_PERF_EN
    checks++;
    if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_perf: got fetch=%0d stall=%0d expected 0 0", perf_fetch_cnt, perf_stall_cnt);
    end
`endif
    bus.commit_valid = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8000_0000) begin
      failures++;
      $display("FAIL release_req: got valid=%b addr=%h expected 1 80000000", bus.mem_req_valid, bus.mem_req_addr);
    end
  endtask

  task automatic test_basic();
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    checks++;
    if (bus.mem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_cycle1: got req=%b inst=%b expected 0 0", bus.mem_req_valid, bus.inst_valid);
    end
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h0000_0013;
    tick();
    bus.mem_resp_valid = 1'b0;
    checks++;
    if (bus.inst_valid !== 1'b1 || bus.inst_o !== 32'h0000_0013 || bus.pc_o !== 32'h8000_0000) begin
      failures++;
      $display("FAIL basic_cycle2: got valid=%b inst=%h pc=%h expected 1 00000013 80000000",
               bus.inst_valid, bus.inst_o, bus.pc_o);
    end
    commit(1'b0, 32'h0);
    checks++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8000_0004) begin
      failures++;
      $display("FAIL basic_next_req: got valid=%b addr=%h expected 1 80000004", bus.mem_req_valid, bus.mem_req_addr);
    end
`ifdef YSYX_25060170_IFU_PERF_EN
    checks++;
    if (perf_fetch_cnt !== 32'd1) begin
      failures++; $display("FAIL basic_perf_fetch: got %0d expected 1", perf_fetch_cnt);
    end
`endif
  endtask

  task automatic test_req_stall();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8000_0000) begin
        failures++;
        $display("FAIL stall_hold_%0d: got valid=%b addr=%h expected 1 80000000", i, bus.mem_req_valid, bus.mem_req_addr);
      end
    end
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    tick();
    checks++;
    if (bus.mem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_in_resp: got req=%b inst=%b expected 0 0", bus.mem_req_valid, bus.inst_valid);
    end
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h0000_0113;
    tick();
    bus.mem_resp_valid = 1'b0;
    checks++;
    if (bus.inst_valid !== 1'b1 || bus.inst_o !== 32'h0000_0113) begin
      failures++;
      $display("FAIL stall_deliver: got valid=%b inst=%h expected 1 00000113", bus.inst_valid, bus.inst_o);
    end
    commit(1'b0, 32'h0);
  endtask

  task automatic test_deliver_hold();
    fetch_word(32'h0010_0093, 32'h8000_0004);
    for (int i = 0; i < 4; i++) begin
      bus.mem_resp_valid = (i % 2 == 0);
      bus.mem_resp_data  = 32'hDEAD_BEEF;
      bus.commit_valid   = (i == 1);
      bus.commit_jump    = 1'b1;
      bus.commit_target  = 32'h0000_0040;
      tick();
      checks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_o !== 32'h0010_0093 ||
          bus.pc_o !== 32'h8000_0004 || bus.mem_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL deliver_hold_%0d: got valid=%b inst=%h pc=%h req=%b expected 1 00100093 80000004 0",
                 i, bus.inst_valid, bus.inst_o, bus.pc_o, bus.mem_req_valid);
      end
    end
    idle_inputs();
    commit(1'b0, 32'h0);
    checks++;
    if (bus.mem_req_addr !== 32'h8000_0008) begin
      failures++; $display("FAIL deliver_next_req: got %h expected 80000008", bus.mem_req_addr);
    end
  endtask

  task automatic test_jump();
    fetch_word(32'h0000_006F, 32'h8000_0008);
    commit(1'b1, 32'h8000_0103);
    checks++;
    if (bus.mem_req_addr !== 32'h8000_0100 || bus.pc_o !== 32'h8000_0100) begin
      failures++;
      $display("FAIL jump_target: got addr=%h pc=%h expected 80000100", bus.mem_req_addr, bus.pc_o);
    end
  endtask

  task automatic test_wrap();
    fetch_word(32'h0000_0067, 32'h8000_0100);
    commit(1'b1, 32'hFFFF_FFFF);
    checks++;
    if (bus.mem_req_addr !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_jump: got %h expected fffffffc", bus.mem_req_addr);
    end
    fetch_word(32'h0000_0013, 32'hFFFF_FFFC);
    commit(1'b0, 32'h0);
    checks++;
    if (bus.mem_req_addr !== 32'h0000_0000) begin
      failures++; $display("FAIL wrap_seq: got %h expected 00000000", bus.mem_req_addr);
    end
  endtask

  task automatic test_reset_mid();
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    bus.commit_valid = 1'b1;
    tick();
    checks++;
    if (bus.mem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0 ||
        bus.pc_o !== 32'h8000_0000 || bus.inst_o !== 32'h0) begin
      failures++;
      $display("FAIL midreset_state: got req=%b inst_valid=%b pc=%h inst=%h expected 0 0 80000000 00000000",
               bus.mem_req_valid, bus.inst_valid, bus.pc_o, bus.inst_o);
    end
`ifdef YSYX_25060170_IFU_PERF_EN
    checks++;
    if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL midreset_perf: got fetch=%0d stall=%0d expected 0 0", perf_fetch_cnt, perf_stall_cnt);
    end
`endif
    bus.commit_valid   = 1'b0;
    rst                = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hDEAD_BEEF;
    tick();
    bus.mem_resp_valid = 1'b0;
    tick();
    checks++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8000_0000 ||
        bus.inst_valid !== 1'b0 || bus.inst_o !== 32'h0) begin
      failures++;
      $display("FAIL midreset_stale: got req=%b addr=%h inst_valid=%b inst=%h expected 1 80000000 0 00000000",
               bus.mem_req_valid, bus.mem_req_addr, bus.inst_valid, bus.inst_o);
    end
    fetch_word(32'h0020_0113, 32'h8000_0000);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_req_stall();
    test_deliver_hold();
    test_jump();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_25060170_ifu_fetch.md
Name: ysyx_25060170_ifu_fetch

Overview:
Multi-cycle instruction fetch stage placed upstream of the decode unit. It replaces the combinational PC-to-instruction path with a request/response handshake to instruction memory and a valid/ready handshake to decode. It holds the PC. It does not fetch again until the downstream stages signal commit of the current instruction, together with any jump redirect. The core is non-pipelined, so at most one instruction is in flight.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
mem_req_valid  out  1  fetch request valid
mem_req_addr  out  32  fetch address (equals pc)
mem_req_ready  in  1  memory accepts request
mem_resp_valid  in  1  instruction word returned
mem_resp_data  in  32  returned instruction word
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst_o  out  32  held instruction word
pc_o  out  32  PC of inst_o
commit_valid  in  1  one-cycle pulse: current instruction retired
commit_jump  in  1  retired instruction redirects the PC
commit_target  in  32  redirect address

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=RESET_PC, state=REQ, inst_o=0.
  - mem_req_valid=0 and inst_valid=0 while rst is high.
  - Reset asserted mid-operation aborts everything, including a pending memory response.
- State machine:
  - REQ: mem_req_valid=1, mem_req_addr=pc. On mem_req_ready=1, go to RESP.
  - RESP: wait for mem_resp_valid. On the response edge, latch inst_o=mem_resp_data and go to DELIVER. mem_resp_valid is ignored in every other state.
  - DELIVER: inst_valid=1. inst_o and pc_o stay stable until inst_ready=1, then go to COMMIT.
  - COMMIT: wait for commit_valid. On commit, pc = commit_jump ? {commit_target[31:2],2'b00} : pc+4, then go to REQ.
- Outputs: mem_req_valid and inst_valid are decoded from state only; they have no combinational path from any input.
- Minimum latency with memory ready every cycle: request accepted in cycle 0; earliest response in cycle 1, which fires the RESP→DELIVER edge; inst_valid=1 in cycle 2.
- Zero-latency response (valid in the same cycle as request acceptance) is not supported; it is ignored.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0). There is no trap.
- commit_valid outside COMMIT is ignored.
- commit_valid together with rst: reset wins.
- pc_o always equals mem_req_addr and pc.

Optional Feature:
- Macro: YSYX_25060170_IFU_PERF_EN.
- When defined, adds outputs:
  - perf_fetch_cnt (32): increments on each DELIVER→COMMIT handshake.
  - perf_stall_cnt (32): increments every cycle spent in REQ with mem_req_ready=0, or in RESP with mem_resp_valid=0.
  - Both counters reset to 0 and wrap at 2^32.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, memory always ready, response 1 cycle after request returning 32'h00000013, inst_ready=1, commit pulse 1 cycle after handshake, no jump → first request addr 32'h8000_0000; inst_valid=1 in cycle 2 with pc_o=32'h8000_0000, inst_o=32'h00000013; next request addr 32'h8000_0004.
- Hold mem_req_ready=0 for 3 cycles, then 1 → mem_req_valid stays 1 and addr stays 32'h8000_0000 throughout; exactly one RESP entry.
- inst_ready=0 for 4 cycles in DELIVER, mem_resp_valid toggled meanwhile with 32'hDEADBEEF → inst_o stays the original word; no state change until inst_ready=1.
- Commit with commit_jump=1, commit_target=32'h8000_0103 → next request addr 32'h8000_0100.
- pc forced to 32'hFFFF_FFFC via jump, then non-jump commit → next request addr 32'h0000_0000.
- Assert rst during RESP, then deliver a stale response the cycle after release → response ignored; next request addr 32'h8000_0000; with PERF_EN both counters read 0 after reset.
